// File: rtl/rr_arbiter_1hot.sv
// Round-robin arbiter producing a registered one-hot grant for the one-hot
// N:1 data muxes. It holds the grant through stalls and keeps it across
// locked bursts. Re-arbitration on a released beat happens in the same cycle,
// so the next grant follows with no idle bubble.
//
// state | meaning
// IDLE  | no grant outstanding, arbitrate on any request
// BUSY  | grant live, waiting for transfer / burst end / abort

module rr_arbiter_1hot #(
   parameter int N    = 8,
   parameter int IDXW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    lock,
   input  logic            out_ready,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] grant_idx,
   output logic            grant_vld,
   output logic            xfer
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [IDXW-1:0] LAST_RST = IDXW'(N - 1);

   state_t            state, state_nxt;
   logic [N-1:0]      grant_nxt;
   logic [IDXW-1:0]   idx_nxt;
   logic [IDXW-1:0]   last, last_nxt;
   logic [IDXW-1:0]   scan_from;
   logic [IDXW-1:0]   cand;
   logic [IDXW-1:0]   win_idx;
   logic              win_found;

   assign grant_vld = (state == BUSY);
   assign xfer      = grant_vld & out_ready;

   // While a grant is live the holder becomes lowest priority on release,
   // so the scan starts after the current index rather than the stored pointer.
   assign scan_from = (state == BUSY) ? grant_idx : last;

   // Pick the first set request scanning scan_from+1, scan_from+2 ... mod N.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IDXW'((int'(scan_from) + k) % N);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and next-grant selection.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      idx_nxt   = grant_idx;
      last_nxt  = last;
      if (state == IDLE) begin
         if (win_found) begin
            state_nxt = BUSY;
            grant_nxt = {{(N-1){1'b0}}, 1'b1} << win_idx;
            idx_nxt   = win_idx;
         end
      end else begin
         if (out_ready) begin
            if (!lock[grant_idx]) begin
               last_nxt = grant_idx;
               if (win_found) begin
                  grant_nxt = {{(N-1){1'b0}}, 1'b1} << win_idx;
                  idx_nxt   = win_idx;
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
               end
            end
         end else if (!req[grant_idx]) begin
            // requester withdrew without transferring: drop the grant
            last_nxt  = grant_idx;
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      end
   end

   // State, grant and priority pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         grant_idx <= '0;
         last      <= LAST_RST;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         grant_idx <= idx_nxt;
         last      <= last_nxt;
      end
   end

   // Grant must stay a legal mux select at all times.
   assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(grant) && (grant_vld == (|grant)) && (!grant_vld || grant[grant_idx]));

endmodule
